fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 44 ++++
 rtl/fifo_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

  // Even parity of the byte, inverted when odd parity is selected.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end,
  output logic bit_near_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  // One cycle before the boundary; lets the parent register boundary-aligned pulses.
  localparam logic [CW-1:0] NEAR = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise increment with wrap at the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end      = (cnt_q == LAST);
  assign bit_near_end = (cnt_q == NEAR);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the byte FIFO and serialises them as UART frames on tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              empty,
  input  logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              fd_q, fd_d;
  logic              bit_end;
  logic              bit_near_end;
  logic              baud_clear;

  // Restart the bit timer so the start bit gets a full period.
  assign baud_clear = (state_q == LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .clear       (baud_clear),
    .bit_end     (bit_end),
    .bit_near_end(bit_near_end)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    read_d     = 1'b0;
    fd_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_en && !empty) begin
          read_d  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shreg_d    = data_out;
        par_d      = calc_parity(data_out, PAR_ODD);
        bit_idx_d  = 3'd0;
        stop_idx_d = 1'b0;
        state_d    = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = PAR_EN ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        // Raised one cycle early so the registered pulse lands on the final stop cycle.
        fd_d = (stop_idx_q == STOP_LAST) && bit_near_end;
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    // The line level follows the state being entered so tx lines up with the state register.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      fd_q       <= fd_d;
    end
  end

  assign tx         = tx_q;
  assign read       = read_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a small FIFO model.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset   = 1'b1;
  logic       tx_en   = 1'b0;
  logic       tx_en_p = 1'b0;
  logic       empty;
  logic [7:0] data_out = 8'h00;
  logic       read, tx, busy, frame_done;
  logic       read_pe, tx_pe, busy_pe, fd_pe;
  logic       read_po, tx_po, busy_po, fd_po;

  int checks = 0;
  int errors = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .empty(empty), .data_out(data_out),
    .read(read), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_pe (
    .clk(clk), .reset(reset), .tx_en(tx_en_p), .empty(1'b0), .data_out(8'h07),
    .read(read_pe), .tx(tx_pe), .busy(busy_pe), .frame_done(fd_pe)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
    .clk(clk), .reset(reset), .tx_en(tx_en_p), .empty(1'b0), .data_out(8'h07),
    .read(read_po), .tx(tx_po), .busy(busy_po), .frame_done(fd_po)
  );

  // FIFO model: data appears the cycle after read is sampled.
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int read_cnt = 0;
  int bad_read = 0;
  assign empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (read === 1'b1) begin
      data_out <= mem[rd_ptr % 16];
      rd_ptr   <= rd_ptr + 1;
      read_cnt <= read_cnt + 1;
      if (empty) bad_read <= bad_read + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  logic tx_log [0:99];
  logic fd_log [0:99];
  logic rd_log [0:99];
  logic busy_log [0:99];
  logic txpe_log [0:99];
  logic txpo_log [0:99];
  logic fdpe_log [0:99];
  logic busype_log [0:99];

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tx_log[k]     = tx;
      fd_log[k]     = frame_done;
      rd_log[k]     = read;
      busy_log[k]   = busy;
      txpe_log[k]   = tx_pe;
      txpo_log[k]   = tx_po;
      fdpe_log[k]   = fd_pe;
      busype_log[k] = busy_pe;
    end
  endtask

  // Waits (bounded) for a read pulse on the main (sel=0) or parity (sel=1) instance.
  task automatic wait_read(input string name, input int limit, input int sel);
    logic got;
    got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if ((sel == 0 && read === 1'b1) || (sel == 1 && read_pe === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL %s: no read pulse within %0d clks (required one)", name, limit);
    end
  endtask

  task automatic test_reset();
    push(8'hA5);
    reset = 1'b1;
    tx_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
      checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", read); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (read !== 1'b1) begin errors++; $display("FAIL first_read: got %b want 1", read); end
  endtask

  task automatic test_single_byte();
    logic [9:0] fr;
    int fd_n, rd_n;
    fr = {1'b1, 8'hA5, 1'b0};
    record(42);
    checks++; if (tx_log[0] !== 1'b1) begin errors++; $display("FAIL sb_load_tx: got %b want 1", tx_log[0]); end
    for (int k = 1; k <= 40; k++) begin
      checks++;
      if (tx_log[k] !== fr[(k-1)/4]) begin
        errors++; $display("FAIL sb_tx[%0d]: got %b want %b", k, tx_log[k], fr[(k-1)/4]);
      end
    end
    fd_n = 0; rd_n = 0;
    for (int k = 0; k < 42; k++) begin
      if (fd_log[k] === 1'b1) fd_n++;
      if (rd_log[k] === 1'b1) rd_n++;
    end
    checks++; if (fd_n != 1) begin errors++; $display("FAIL sb_fd_count: got %0d want 1", fd_n); end
    checks++; if (fd_log[40] !== 1'b1) begin errors++; $display("FAIL sb_fd_pos: got %b want 1", fd_log[40]); end
    checks++; if (rd_n != 0) begin errors++; $display("FAIL sb_extra_read: got %0d want 0", rd_n); end
    checks++; if (read_cnt != 1) begin errors++; $display("FAIL sb_read_cnt: got %0d want 1", read_cnt); end
    checks++; if (busy_log[40] !== 1'b1) begin errors++; $display("FAIL sb_busy_stop: got %b want 1", busy_log[40]); end
    checks++; if (busy_log[41] !== 1'b0) begin errors++; $display("FAIL sb_busy_idle: got %b want 0", busy_log[41]); end
  endtask

  task automatic test_back_to_back();
    int base, gap;
    logic ok0, ok1;
    base = read_cnt;
    push(8'h00);
    push(8'hFF);
    wait_read("b2b_read1", 20, 0);
    record(86);
    checks++; if (fd_log[40] !== 1'b1 || tx_log[40] !== 1'b1) begin
      errors++; $display("FAIL b2b_stop1: got fd=%b tx=%b want fd=1 tx=1", fd_log[40], tx_log[40]);
    end
    gap = 0;
    for (int k = 41; k < 60; k++) begin
      if (tx_log[k] !== 1'b1) break;
      gap++;
    end
    checks++; if (gap != 3) begin errors++; $display("FAIL b2b_gap: got %0d want 3", gap); end
    checks++; if (rd_log[42] !== 1'b1) begin errors++; $display("FAIL b2b_read2_pos: got %b want 1", rd_log[42]); end
    ok0 = 1'b1; ok1 = 1'b1;
    for (int k = 1; k <= 36; k++) if (tx_log[k] !== 1'b0) ok0 = 1'b0;
    for (int k = 48; k <= 83; k++) if (tx_log[k] !== 1'b1) ok1 = 1'b1 & 1'b0;
    checks++; if (ok0 !== 1'b1) begin errors++; $display("FAIL b2b_frame1_bits: got mismatch want all 0"); end
    checks++; if (ok1 !== 1'b1) begin errors++; $display("FAIL b2b_frame2_bits: got mismatch want all 1"); end
    checks++; if (fd_log[83] !== 1'b1) begin errors++; $display("FAIL b2b_fd2: got %b want 1", fd_log[83]); end
    checks++; if (read_cnt != base + 2) begin errors++; $display("FAIL b2b_reads: got %0d want %0d", read_cnt - base, 2); end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    int fd_n;
    logic ok;
    b = 8'h07;
    tx_en_p = 1'b1;
    wait_read("par_read", 20, 1);
    tx_en_p = 1'b0;
    record(46);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (txpe_log[5 + 4*i + 1] !== b[i]) begin
        errors++; $display("FAIL par_data[%0d]: got %b want %b", i, txpe_log[5 + 4*i + 1], b[i]);
      end
    end
    checks++; if (txpe_log[38] !== 1'b1) begin errors++; $display("FAIL par_even: got %b want 1", txpe_log[38]); end
    checks++; if (txpo_log[38] !== 1'b0) begin errors++; $display("FAIL par_odd: got %b want 0", txpo_log[38]); end
    ok = 1'b1;
    for (int k = 41; k <= 44; k++) if (txpe_log[k] !== 1'b1) ok = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL par_stop: got non-high stop want 1"); end
    fd_n = 0;
    for (int k = 0; k < 46; k++) if (fdpe_log[k] === 1'b1) fd_n++;
    checks++; if (fdpe_log[44] !== 1'b1 || fd_n != 1) begin
      errors++; $display("FAIL par_len11: got fd44=%b count=%0d want 1 and 1", fdpe_log[44], fd_n);
    end
    checks++; if (busype_log[44] !== 1'b1 || busype_log[45] !== 1'b0) begin
      errors++; $display("FAIL par_busy: got %b%b want 10", busype_log[44], busype_log[45]);
    end
  endtask

  task automatic test_flow_control();
    int base;
    logic ok;
    tx_en = 1'b0;
    base = read_cnt;
    push(8'h3C);
    push(8'h81);
    ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (read !== 1'b0 || tx !== 1'b1) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flow_idle: got activity want read=0 tx=1"); end
    checks++; if (read_cnt != base) begin errors++; $display("FAIL flow_reads: got %0d want 0", read_cnt - base); end
  endtask

  task automatic test_tx_en_drop();
    int base, n;
    logic ok;
    base = read_cnt;
    tx_en = 1'b1;
    wait_read("drop_read", 20, 0);
    repeat (18) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL drop_bit3: got %b want 1", tx); end
    tx_en = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) break;
    end
    checks++; if (n != 23) begin errors++; $display("FAIL drop_complete: got %0d clks want 23", n); end
    ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (read !== 1'b0) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL drop_no_read: got read want none"); end
    checks++; if (read_cnt != base + 1) begin errors++; $display("FAIL drop_reads: got %0d want 1", read_cnt - base); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [7:0] b;
    b = 8'h5A;
    push(b);
    tx_en = 1'b1;
    wait_read("rst_read", 20, 0);
    repeat (27) @(negedge clk);
    checks++; if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b0;
    base = read_cnt;
    wait_read("rst_next_read", 5, 0);
    record(42);
    checks++; if (tx_log[2] !== 1'b0) begin errors++; $display("FAIL rst_next_start: got %b want 0", tx_log[2]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_log[5 + 4*i + 1] !== b[i]) begin
        errors++; $display("FAIL rst_next_data[%0d]: got %b want %b", i, tx_log[5 + 4*i + 1], b[i]);
      end
    end
    checks++; if (fd_log[40] !== 1'b1 || tx_log[38] !== 1'b1) begin
      errors++; $display("FAIL rst_next_stop: got fd=%b tx=%b want 1 1", fd_log[40], tx_log[38]);
    end
    checks++; if (read_cnt != base + 1) begin errors++; $display("FAIL rst_next_reads: got %0d want 1", read_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_flow_control();
    test_tx_en_drop();
    test_reset_mid_frame();
    checks++; if (bad_read != 0) begin errors++; $display("FAIL read_when_empty: got %0d want 0", bad_read); end
    checks++; if (rd_ptr != wr_ptr) begin errors++; $display("FAIL fifo_drained: got rd=%0d want %0d", rd_ptr, wr_ptr); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
